// File: rtl/conway_mem_pkg.sv
// Shared types and sizing helpers for the Conway system memory.
package conway_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    OUT  = 2'd2
  } mode_t;

  function automatic int beats(input int data_size, input int lanes);
    return (lanes > 0) ? (data_size / lanes) : 0;
  endfunction

  // A single-beat transfer still needs a 1-bit counter to keep ports legal.
  function automatic int count_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/beat_counter.sv
// Modulo-BEATS beat counter shared by the serial load and readout paths.
module beat_counter #(
  parameter int BEATS = 4,
  parameter int CW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          restart,
  output logic [CW-1:0] count,
  output logic          wrap
);

  logic [CW-1:0] base;

  // restart makes this edge behave as beat 0 of a fresh sequence.
  assign base = restart ? '0 : count;
  assign wrap = enable && (base == CW'(BEATS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= wrap ? '0 : (base + CW'(1));
    end
  end

endmodule

// File: rtl/system_memory_v4.sv
// Grid memory: parallel RUN load, multi-lane serial LOAD and non-destructive serial readout.
module system_memory_v4
  import conway_mem_pkg::*;
#(
  parameter int GRID_W = 5,
  parameter int GRID_H = 1,
  parameter int LANES  = 1,
  parameter int GEN_W  = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic [GRID_W*GRID_H-1:0]   GRID_IN,
  input  logic [LANES-1:0]           SERIAL_IN,
  input  logic                       LOAD_MODE,
  input  logic                       RUN_MODE,
  input  logic                       OUTPUT_MODE,
  output logic [GRID_W*GRID_H-1:0]   SYSTEM_MEM_OUT,
  output logic [LANES-1:0]           SERIAL_OUT,
  output logic                       OUT_VALID,
  output logic                       LOAD_DONE,
  output logic                       OUTPUT_DONE,
  output logic [GEN_W-1:0]           GEN_COUNT,
  output logic [1:0]                 debug_state
);

  localparam int DATA_SIZE = GRID_W * GRID_H;
  localparam int BEATS     = beats(DATA_SIZE, LANES);
  localparam int CW        = count_width(BEATS);

  if ((LANES < 1) || (LANES > DATA_SIZE) || ((DATA_SIZE % LANES) != 0)) begin : g_bad_lanes
    $fatal(1, "system_memory_v4: LANES must divide GRID_W*GRID_H");
  end

  mode_t                mode;
  mode_t                state;
  logic                 load_en;
  logic                 out_en;
  logic                 restart;
  logic [CW-1:0]        count;
  logic                 wrap;
  logic                 load_wrap;
  logic                 out_wrap;
  logic [DATA_SIZE-1:0] mem;
  logic [DATA_SIZE-1:0] shadow;
  logic [DATA_SIZE-1:0] snap;
  logic [DATA_SIZE-1:0] mem_shift;

  // RUN wins over everything and counts as IDLE for the beat counter.
  always_comb begin
    mode = IDLE;
    if (RUN_MODE) begin
      mode = IDLE;
    end else if (LOAD_MODE) begin
      mode = LOAD;
    end else if (OUTPUT_MODE) begin
      mode = OUT;
    end
  end

  assign load_en   = (mode == LOAD);
  assign out_en    = (mode == OUT);
  assign restart   = (mode != state);
  assign load_wrap = wrap && load_en;
  assign out_wrap  = wrap && out_en;

  beat_counter #(
    .BEATS (BEATS),
    .CW    (CW)
  ) u_beat_counter (
    .clk     (CLK),
    .rst     (RESET),
    .clear   (!(load_en || out_en)),
    .enable  (load_en || out_en),
    .restart (restart),
    .count   (count),
    .wrap    (wrap)
  );

  if (LANES == DATA_SIZE) begin : g_single_beat
    assign mem_shift = SERIAL_IN;
  end else begin : g_multi_beat
    assign mem_shift = {mem[DATA_SIZE-LANES-1:0], SERIAL_IN};
  end

  // Readout works on a private copy so the stored grid is never disturbed.
  assign snap = ((state != OUT) || (count == '0)) ? mem : shadow;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      mem         <= '0;
      shadow      <= '0;
      SERIAL_OUT  <= '0;
      OUT_VALID   <= 1'b0;
      LOAD_DONE   <= 1'b0;
      OUTPUT_DONE <= 1'b0;
      GEN_COUNT   <= '0;
    end else begin
      state       <= mode;
      SERIAL_OUT  <= '0;
      OUT_VALID   <= 1'b0;
      LOAD_DONE   <= 1'b0;
      OUTPUT_DONE <= 1'b0;
      if (RUN_MODE) begin
        mem       <= GRID_IN;
        GEN_COUNT <= GEN_COUNT + GEN_W'(1);
      end else if (load_en) begin
        mem       <= mem_shift;
        LOAD_DONE <= load_wrap;
        if (load_wrap) begin
          GEN_COUNT <= '0;
        end
      end else if (out_en) begin
        SERIAL_OUT  <= snap[DATA_SIZE-1 -: LANES];
        shadow      <= snap << LANES;
        OUT_VALID   <= 1'b1;
        OUTPUT_DONE <= out_wrap;
      end
    end
  end

  assign SYSTEM_MEM_OUT = mem;
  assign debug_state    = state;

endmodule

// File: tb/tb_system_memory_v4.sv
// Directed scoreboard bench for system_memory_v4 with a 4x2 grid over 2 lanes.
module tb_system_memory_v4;

  localparam int GRID_W = 4;
  localparam int GRID_H = 2;
  localparam int LANES  = 2;
  localparam int GEN_W  = 8;
  localparam int DS     = GRID_W * GRID_H;

  logic             clk;
  logic             rst;
  logic [DS-1:0]    grid_in;
  logic [LANES-1:0] serial_in;
  logic             load_mode;
  logic             run_mode;
  logic             output_mode;
  logic [DS-1:0]    mem_out;
  logic [LANES-1:0] serial_out;
  logic             out_valid;
  logic             load_done;
  logic             output_done;
  logic [GEN_W-1:0] gen_count;
  logic [1:0]       debug_state;

  typedef struct {
    string      name;
    logic [7:0] mem;
    logic [7:0] gen;
    logic       ld;
    logic       od;
    logic       ov;
  } exp_t;

  exp_t       cyc_q[$];
  logic [1:0] exp_q[$];
  int         checks   = 0;
  int         failures = 0;

  system_memory_v4 #(
    .GRID_W (GRID_W),
    .GRID_H (GRID_H),
    .LANES  (LANES),
    .GEN_W  (GEN_W)
  ) dut (
    .CLK            (clk),
    .RESET          (rst),
    .GRID_IN        (grid_in),
    .SERIAL_IN      (serial_in),
    .LOAD_MODE      (load_mode),
    .RUN_MODE       (run_mode),
    .OUTPUT_MODE    (output_mode),
    .SYSTEM_MEM_OUT (mem_out),
    .SERIAL_OUT     (serial_out),
    .OUT_VALID      (out_valid),
    .LOAD_DONE      (load_done),
    .OUTPUT_DONE    (output_done),
    .GEN_COUNT      (gen_count),
    .debug_state    (debug_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Driver: one call is one clock edge; the expected post-edge state is queued.
  task automatic step(input string name, input logic run, input logic ld, input logic om,
                      input logic [1:0] ser, input logic [7:0] grid,
                      input logic [7:0] emem, input logic [7:0] egen,
                      input logic eld, input logic eod, input logic eov, input logic [1:0] eser);
    exp_t e;
    @(negedge clk);
    run_mode    = run;
    load_mode   = ld;
    output_mode = om;
    serial_in   = ser;
    grid_in     = grid;
    @(posedge clk);
    e.name = name;
    e.mem  = emem;
    e.gen  = egen;
    e.ld   = eld;
    e.od   = eod;
    e.ov   = eov;
    cyc_q.push_back(e);
    if (eov) exp_q.push_back(eser);
  endtask

  task automatic zero_checks(input string tag);
    check({tag, "_mem"},  mem_out, 8'h00);
    check({tag, "_ser"},  {6'd0, serial_out}, 8'h00);
    check({tag, "_ov"},   {7'd0, out_valid}, 8'h00);
    check({tag, "_ld"},   {7'd0, load_done}, 8'h00);
    check({tag, "_od"},   {7'd0, output_done}, 8'h00);
    check({tag, "_gen"},  gen_count, 8'h00);
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (cyc_q.size() > 0) begin
        exp_t e;
        e = cyc_q.pop_front();
        check({e.name, "_mem"}, mem_out, e.mem);
        check({e.name, "_gen"}, gen_count, e.gen);
        check({e.name, "_load_done"}, {7'd0, load_done}, {7'd0, e.ld});
        check({e.name, "_output_done"}, {7'd0, output_done}, {7'd0, e.od});
        check({e.name, "_out_valid"}, {7'd0, out_valid}, {7'd0, e.ov});
        if (!e.ov) check({e.name, "_serial_idle"}, {6'd0, serial_out}, 8'h00);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%b required=no_beat", serial_out);
        end else begin
          logic [1:0] s;
          s = exp_q.pop_front();
          check("serial_beat", {6'd0, serial_out}, {6'd0, s});
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    grid_in = '0;
    serial_in = '0;
    load_mode = 1'b0;
    run_mode = 1'b0;
    output_mode = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    zero_checks("reset");

    // Idle edges must not pick up GRID_IN or SERIAL_IN
    for (int i = 0; i < 3; i++)
      step("idle", 0, 0, 0, 2'b11, 8'hA5, 8'h00, 8'h00, 0, 0, 0, 2'b00);

    // Serial load of 9C, done pulse only after the fourth beat
    step("load1", 0, 1, 0, 2'b10, 8'hA5, 8'h02, 8'h00, 0, 0, 0, 2'b00);
    step("load2", 0, 1, 0, 2'b01, 8'hA5, 8'h09, 8'h00, 0, 0, 0, 2'b00);
    step("load3", 0, 1, 0, 2'b11, 8'hA5, 8'h27, 8'h00, 0, 0, 0, 2'b00);
    step("load4", 0, 1, 0, 2'b00, 8'hA5, 8'h9C, 8'h00, 1, 0, 0, 2'b00);
    step("load5", 0, 0, 0, 2'b00, 8'hA5, 8'h9C, 8'h00, 0, 0, 0, 2'b00);

    // RUN beats LOAD and OUTPUT; a completed load clears the generation count
    step("prio1", 1, 1, 1, 2'b11, 8'h3C, 8'h3C, 8'h01, 0, 0, 0, 2'b00);
    step("prio2", 1, 1, 1, 2'b11, 8'h3C, 8'h3C, 8'h02, 0, 0, 0, 2'b00);
    step("prio3", 1, 1, 1, 2'b11, 8'h3C, 8'h3C, 8'h03, 0, 0, 0, 2'b00);
    step("reload1", 0, 1, 0, 2'b10, 8'h00, 8'hF2, 8'h03, 0, 0, 0, 2'b00);
    step("reload2", 0, 1, 0, 2'b01, 8'h00, 8'hC9, 8'h03, 0, 0, 0, 2'b00);
    step("reload3", 0, 1, 0, 2'b11, 8'h00, 8'h27, 8'h03, 0, 0, 0, 2'b00);
    step("reload4", 0, 1, 0, 2'b00, 8'h00, 8'h9C, 8'h00, 1, 0, 0, 2'b00);

    // Readout MSB lanes first, then wrap to a fresh snapshot
    step("rd1", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b10);
    step("rd2", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b01);
    step("rd3", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b11);
    step("rd4", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 1, 1, 2'b00);
    step("rd5", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b10);

    // Abort mid-readout, then restart from beat 0
    step("ab_idle0", 0, 0, 0, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 0, 2'b00);
    step("ab_rd1", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b10);
    step("ab_rd2", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b01);
    step("ab_idle", 0, 0, 0, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 0, 2'b00);
    step("re_rd1", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b10);
    step("re_rd2", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b01);
    step("re_rd3", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 1, 2'b11);
    step("re_rd4", 0, 0, 1, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 1, 1, 2'b00);
    step("re_idle", 0, 0, 0, 2'b00, 8'h00, 8'h9C, 8'h00, 0, 0, 0, 2'b00);

    // Asynchronous reset between edges during a load
    step("pre_run", 1, 0, 0, 2'b00, 8'h5A, 8'h5A, 8'h01, 0, 0, 0, 2'b00);
    step("rl1", 0, 1, 0, 2'b01, 8'h00, 8'h69, 8'h01, 0, 0, 0, 2'b00);
    step("rl2", 0, 1, 0, 2'b10, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2'b00);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1 zero_checks("async_reset");
    step("nl1", 0, 1, 0, 2'b11, 8'h00, 8'h03, 8'h00, 0, 0, 0, 2'b00);
    step("nl2", 0, 1, 0, 2'b00, 8'h00, 8'h0C, 8'h00, 0, 0, 0, 2'b00);
    step("nl3", 0, 1, 0, 2'b10, 8'h00, 8'h32, 8'h00, 0, 0, 0, 2'b00);
    step("nl4", 0, 1, 0, 2'b01, 8'h00, 8'hC9, 8'h00, 1, 0, 0, 2'b00);
    step("nl_idle", 0, 0, 0, 2'b00, 8'h00, 8'hC9, 8'h00, 0, 0, 0, 2'b00);

    @(negedge clk);
    @(negedge clk);
    check("cycle_queue_drained", 8'(cyc_q.size()), 8'h00);
    check("beat_queue_drained", 8'(exp_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/system_memory_v4.md
Name: system_memory_v4

Overview:
Next-generation system memory for the Conway grid. It holds one GRID_W x GRID_H generation as a flat bit vector and loads it either in parallel from the next-state logic (RUN) or serially over LANES parallel lanes (LOAD). It reads the grid back out over the same number of lanes (OUTPUT) without disturbing the stored grid. Compared with the previous generation it adds multi-lane serial I/O, beat counting, done/valid strobes and a generation counter.

Parameters:
GRID_W, 5, grid columns
GRID_H, 1, grid rows; DATA_SIZE = GRID_W*GRID_H, bit index = row*GRID_W + col
LANES, 1, serial lanes; must divide DATA_SIZE; BEATS = DATA_SIZE/LANES
GEN_W, 16, generation counter width

Ports:
CLK  input  1  single clock, rising edge
RESET  input  1  asynchronous, active-high reset
GRID_IN  input  DATA_SIZE  next-generation grid from the cell array
SERIAL_IN  input  LANES  serial load data; bit LANES-1 lands in the higher memory bit
LOAD_MODE  input  1  serial load request
RUN_MODE  input  1  parallel load request
OUTPUT_MODE  input  1  serial readout request
SYSTEM_MEM_OUT  output  DATA_SIZE  stored grid
SERIAL_OUT  output  LANES  readout data, MSB lanes first
OUT_VALID  output  1  SERIAL_OUT carries a valid beat
LOAD_DONE  output  1  one-cycle pulse: full grid shifted in
OUTPUT_DONE  output  1  high with the final readout beat
GEN_COUNT  output  GEN_W  RUN loads since the last reset or completed serial load

Behaviour:
- Reset: one clock, asynchronous, active-high. On assert, all outputs, the shadow register, the beat counter and the state go to 0/IDLE immediately, with no clock edge needed.
- Mode priority is evaluated each edge: RUN > LOAD > OUTPUT > idle. States: IDLE, LOAD, OUT, from the decoded mode; RUN is treated as IDLE for counter purposes.
- RUN edge: mem <= GRID_IN; GEN_COUNT <= GEN_COUNT+1, wrapping modulo 2^GEN_W; beat counter <= 0.
- LOAD edge: mem <= {mem[DATA_SIZE-LANES-1:0], SERIAL_IN}; the beat counter increments.
  - On the edge that completes beat BEATS-1, the counter wraps to 0, LOAD_DONE is high for the following cycle only, and GEN_COUNT <= 0.
  - Continued LOAD keeps shifting, with no lockout.
- OUTPUT edge:
  - On the first OUT edge (previous state not OUT) or when the counter is 0, the shadow is snapshotted from mem.
  - SERIAL_OUT <= top LANES bits of the snapshot; shadow <= snapshot << LANES; OUT_VALID <= 1; counter increments.
  - OUTPUT_DONE <= 1 on the edge driving beat BEATS-1, and the counter wraps.
  - mem is never modified in OUTPUT.
- Any non-OUTPUT edge: SERIAL_OUT <= 0, OUT_VALID <= 0, OUTPUT_DONE <= 0.
- Leaving LOAD or OUT mid-sequence aborts it: the counter returns to 0 and mem keeps any partial load. Re-entering OUT restarts from a fresh snapshot.
- Idle edge: mem and GEN_COUNT hold.
- Latency: all outputs are registered; SERIAL_OUT is valid 1 edge after OUTPUT is asserted.
- LANES == DATA_SIZE degenerates to a single-beat transfer. LANES not dividing DATA_SIZE is a fatal elaboration error.

Decomposition:
- Package conway_mem_pkg: mode_t enum (IDLE, LOAD, OUT) and a function beats(DATA_SIZE, LANES).
- One sub-module, beat_counter: modulo-BEATS counter with clear, enable and wrap-strobe, reused by the LOAD and OUT paths.

Test Plan:
All scenarios use GRID_W=4, GRID_H=2, LANES=2 (BEATS=4), GEN_W=8.
1. Idle: reset, then GRID_IN=8'hA5, SERIAL_IN=2'b11, no modes, 3 edges -> SYSTEM_MEM_OUT=8'h00, SERIAL_OUT=0, OUT_VALID=0, GEN_COUNT=0.
2. Serial load: LOAD with SERIAL_IN=10,01,11,00 over 4 edges -> SYSTEM_MEM_OUT=8'h9C; LOAD_DONE=1 for exactly the cycle after edge 4, 0 after edge 3 and edge 5.
3. Priority: RUN+LOAD+OUTPUT, GRID_IN=8'h3C, 3 edges -> SYSTEM_MEM_OUT=8'h3C, GEN_COUNT=3, OUT_VALID=0. Then a 4-beat LOAD -> GEN_COUNT=0.
4. Readout: mem=8'h9C, OUTPUT for 4 edges -> SERIAL_OUT=10,01,11,00 with OUT_VALID=1; OUTPUT_DONE only with beat 4; SYSTEM_MEM_OUT stays 8'h9C. Edge 5 repeats 10.
5. Abort: OUTPUT for 2 edges, then 1 idle edge -> SERIAL_OUT=0 and OUT_VALID=0. Re-assert OUTPUT -> first beat is 10 again.
6. Async reset mid-load: after 2 LOAD beats, pulse RESET for 1 ns between edges -> all outputs 0 before the next edge. A subsequent LOAD asserts LOAD_DONE only after 4 new beats.
